// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - handshake and HI/LO bus between control and muldiv_unit
//
// Purpose: groups the operand, command and result signals of the multiply/divide unit.
// Ports (master = control unit side, slave = muldiv_unit):
//   data1, data2  operands A and B, sampled with start
//   mdOp          00 mult, 01 multu, 10 div, 11 divu
//   start         operation request, taken only while busy=0
//   writeHi/Lo    mthi/mtlo strobes, data on wrData
//   busy, done    operation in progress / one-cycle result pulse
//   divByZero     valid with done
//   hi, lo        architectural HI/LO registers
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] data1;
  logic [WIDTH-1:0] data2;
  logic [1:0]       mdOp;
  logic             start;
  logic             writeHi;
  logic             writeLo;
  logic [WIDTH-1:0] wrData;
  logic             busy;
  logic             done;
  logic             divByZero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output data1, data2, mdOp, start, writeHi, writeLo, wrData,
    input  busy, done, divByZero, hi, lo
  );

  modport slave (
    input  data1, data2, mdOp, start, writeHi, writeLo, wrData,
    output busy, done, divByZero, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative mult/multu/div/divu unit with HI/LO registers
//
// Purpose: radix-2 shift-add multiplier and restoring divider sharing one
// 2*WIDTH accumulator; one step per cycle, WIDTH steps, then a sign/fixup cycle.
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      muldiv_unit_if slave modport (operands, start, mthi/mtlo, busy/done, hi/lo)
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  muldiv_unit_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;
  logic               neg_rem_q, neg_rem_d;
  logic               zero_div_q, zero_div_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;

  // Operand conditioning at start: signed ops iterate on magnitudes.
  logic             signed_op;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign signed_op = ~bus.mdOp[0];
  assign a_neg     = signed_op & bus.data1[WIDTH-1];
  assign b_neg     = signed_op & bus.data2[WIDTH-1];
  assign a_mag     = a_neg ? -bus.data1 : bus.data1;
  assign b_mag     = b_neg ? -bus.data2 : bus.data2;

  // Multiply step: add multiplicand into the upper half when the low bit is
  // set, then shift the whole product right (carry enters at the top).
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;

  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Divide step: the shifted partial remainder needs WIDTH+1 bits. Since it is
  // always below 2*divisor, bit WIDTH of the WIDTH+1-bit difference is a clean
  // borrow flag.
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] div_next;

  assign rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_diff = rem_sh - {1'b0, opb_q};
  assign div_next = div_diff[WIDTH] ? {rem_sh[WIDTH-1:0],   acc_q[WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

  // Sign fixup for the FINISH cycle.
  logic [2*WIDTH-1:0] prod_f;
  logic [WIDTH-1:0]   quot_f, rem_f;

  assign prod_f = neg_q ? -acc_q : acc_q;
  assign quot_f = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_f  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    opb_d      = opb_q;
    dvd_d      = dvd_q;
    is_div_d   = is_div_q;
    neg_d      = neg_q;
    neg_rem_d  = neg_rem_q;
    zero_div_d = zero_div_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    dbz_d      = dbz_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          // start has priority; mthi/mtlo in the same cycle are dropped
          state_d    = S_RUN;
          cnt_d      = '0;
          busy_d     = 1'b1;
          acc_d      = {{WIDTH{1'b0}}, a_mag};
          opb_d      = b_mag;
          dvd_d      = bus.data1;
          is_div_d   = bus.mdOp[1];
          neg_d      = a_neg ^ b_neg;
          neg_rem_d  = a_neg;
          zero_div_d = bus.mdOp[1] & (bus.data2 == '0);
        end else begin
          if (bus.writeHi) hi_d = bus.wrData;
          if (bus.writeLo) lo_d = bus.wrData;
        end
      end

      S_RUN: begin
        acc_d = is_div_q ? div_next : mul_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_STEP) state_d = S_FINISH;
      end

      S_FINISH: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        cnt_d   = '0;
        dbz_d   = 1'b0;
        if (!is_div_q) begin
          {hi_d, lo_d} = prod_f;
        end else if (zero_div_q) begin
          // divide by zero still runs full latency; HI returns the raw dividend
          lo_d  = '1;
          hi_d  = dvd_q;
          dbz_d = 1'b1;
        end else begin
          lo_d = quot_f;
          hi_d = rem_f;
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      opb_q      <= '0;
      dvd_q      <= '0;
      is_div_q   <= 1'b0;
      neg_q      <= 1'b0;
      neg_rem_q  <= 1'b0;
      zero_div_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      opb_q      <= opb_d;
      dvd_q      <= dvd_d;
      is_div_q   <= is_div_d;
      neg_q      <= neg_d;
      neg_rem_q  <= neg_rem_d;
      zero_div_q <= zero_div_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      dbz_q      <= dbz_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.divByZero = dbz_q;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit for the MIPS datapath. It implements mult, multu, div and divu into the architectural HI/LO registers, plus mthi/mtlo writes. It sits beside the single-cycle ALU and takes the same operand sources: data1 from the register file and data2 from the ALU mux. Operations run for a fixed number of cycles behind a start/busy/done handshake, and the control unit stalls mfhi/mflo while busy is high.

## Interface
- WIDTH, 32, operand and HI/LO width; all counts below use WIDTH=32
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- data1  input  32  operand A (multiplicand / dividend), sampled at start
- data2  input  32  operand B (multiplier / divisor), sampled at start
- mdOp  input  2  operation: 00 mult (signed), 01 multu, 10 div (signed), 11 divu; sampled at start
- start  input  1  request; accepted only on an edge where busy=0
- writeHi  input  1  mthi: HI <= wrData; honoured only when busy=0 and start=0
- writeLo  input  1  mtlo: LO <= wrData; same rule as writeHi
- wrData  input  32  data for mthi/mtlo
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse when HI/LO receive a new result
- divByZero  output  1  valid with done; 1 if a div/divu had data2=0
- hi  output  32  HI register
- lo  output  32  LO register

## Operation
- Reset (asynchronous, reset_n=0): hi=0, lo=0, busy=0, done=0, divByZero=0, state=IDLE, iteration counter=0. Deasserting reset mid-operation leaves the unit in IDLE with no done pulse.
- States are IDLE, RUN and FINISH.
- IDLE:
  - start=1: latch magnitudes |data1| and |data2| (signed ops) or raw values (unsigned ops); latch the result-sign flags; go to RUN with counter=0.
  - start=0 with writeHi/writeLo: load HI/LO. Both may be asserted in the same cycle.
  - start=1 with writeHi/writeLo: the start wins and the writes are dropped.
- RUN: one radix-2 step per cycle, 32 steps, counter 0..31. Go to FINISH after step 31.
  - Multiply: shift-add into a 64-bit product register.
  - Divide: restoring division.
    - 64-bit remainder/quotient register; shift left, then trial-subtract the divisor from the upper half.
    - If the result is non-negative, keep it and set the quotient bit.
- FINISH: apply the signs, then write HI/LO. Pulse done and return to IDLE.
  - Multiply: product negated if sign(data1)^sign(data2) (signed only). {hi,lo} <= 64-bit product.
  - Divide: lo <= quotient, negated if the signs differ; hi <= remainder, which takes the sign of the dividend (signed only).
- Divide by zero (data2=0 on div/divu):
  - Full latency is kept.
  - lo <= 32'hFFFFFFFF, hi <= data1 as latched at start; divByZero=1 with done.
- Signed overflow (div of 32'h80000000 by 32'hFFFFFFFF): lo=32'h80000000, hi=0, divByZero=0.
- divByZero keeps its value until the next done.
- All arithmetic is modulo 2^32 per half.
- start while busy=1: ignored, with no effect on the operation in flight. writeHi/writeLo while busy=1: ignored.

## Timing
- Start is accepted at edge T0. busy=1 from T0 through T33.
- RUN steps happen on edges T1..T32. The FINISH edge T33 updates hi/lo, sets done=1 and clears busy.
- done falls at T34; busy=0 during the cycle after T33.
- A new start is accepted at the earliest on T34 (back-to-back rate: 34 cycles). mthi/mtlo is likewise accepted from T34.
- Outputs are registered. hi/lo hold their values between updates and never show intermediate values.
- mthi/mtlo: hi/lo change on the same edge that samples writeHi/writeLo, and done is not pulsed.

## Test plan
- Reset: assert reset_n=0 mid-RUN (T10) -> hi=lo=0, busy=0, and no done pulse ever appears for that operation.
- mult, data1=-3 (32'hFFFFFFFD), data2=7 -> at T33 hi=32'hFFFFFFFF, lo=32'hFFFFFFEB, done high exactly one cycle. With multu on the same operands -> hi=32'h00000006, lo=32'hFFFFFFEB.
- div, data1=-7, data2=2 -> lo=32'hFFFFFFFD (-3), hi=32'hFFFFFFFF (-1). With divu, data1=100, data2=7 -> lo=14, hi=2.
- div, data1=5, data2=0 -> lo=32'hFFFFFFFF, hi=5, divByZero=1 with done. div of 32'h80000000 by -1 -> lo=32'h80000000, hi=0.
- Handshake:
  - A second start at T5 with different operands is ignored and the first result stands. A start at T34 is accepted.
  - writeHi=1 with wrData=32'hA5A5A5A5 at T5 is ignored. The same write in IDLE sets hi=32'hA5A5A5A5 on that edge with done=0.
  - start and writeLo in the same cycle -> the operation starts and LO is not written.
